// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, producer
// port indices and the fixed-priority winner picker.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_e;

    localparam int PORT_SW   = 0;
    localparam int PORT_KEY  = 1;
    localparam int PORT_LANG = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [6:0] LANG_BYTE_PREFIX = 7'b0;

    // Language change beats keystroke beats switch bank.
    function automatic logic [NUM_PORTS-1:0] pick_winner(input logic [NUM_PORTS-1:0] pend);
        logic [NUM_PORTS-1:0] win;
        win = '0;
        if (pend[PORT_LANG]) begin
            win[PORT_LANG] = 1'b1;
        end else if (pend[PORT_KEY]) begin
            win[PORT_KEY] = 1'b1;
        end else if (pend[PORT_SW]) begin
            win[PORT_SW] = 1'b1;
        end
        return win;
    endfunction

endpackage

// File: rtl/tx_req_slot.sv
// One-deep holding register for a single byte producer. A request in the
// same cycle as the grant-side clear keeps the slot full with the new byte.
module tx_req_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] data,
    input  logic       clear,
    output logic       pending,
    output logic [7:0] q,
    output logic       overflow
);

    logic       pending_q, pending_d;
    logic [7:0] data_q, data_d;
    logic       overflow_q, overflow_d;

    always_comb begin
        pending_d  = pending_q;
        data_d     = data_q;
        overflow_d = 1'b0;
        if (req) begin
            pending_d  = 1'b1;
            data_d     = data;
            overflow_d = pending_q && !clear;
        end else if (clear) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= 1'b0;
            data_q     <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign q        = data_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between the switch bank, keyboard and language
// flag: three holding slots, a fixed-priority arbiter and a tx_busy tracker.
//
// state        | meaning
// ST_IDLE      | waiting for any pending slot; grants the winner
// ST_SEND      | en_send strobe cycle
// ST_WAIT_BUSY | waiting for tx_busy to rise, with timeout
// ST_WAIT_DONE | byte on the wire, waiting for tx_busy to fall
// ST_GAP       | inter-byte idle spacing
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 8,
    parameter int GAP_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_req,
    input  logic [7:0] sw_data,
    input  logic       key_req,
    input  logic [7:0] key_data,
    input  logic       is_thai,
    input  logic       tx_busy,
    output logic [7:0] send_data,
    output logic       en_send,
    output logic [2:0] grant,
    output logic [2:0] pending,
    output logic       overflow,
    output logic       dropped
);

    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_TC = CNT_W'(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    logic [NUM_PORTS-1:0] slot_req, slot_clear, slot_pending, slot_ovf;
    logic [7:0]           slot_din [NUM_PORTS];
    logic [7:0]           slot_q   [NUM_PORTS];
    logic [NUM_PORTS-1:0] winner;

    logic prev_thai_q, prev_thai_d;

    sched_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           send_data_q, send_data_d;
    logic                 en_send_q, en_send_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 dropped_q, dropped_d;

    // A level change on is_thai is turned into a one-cycle lang request.
    assign prev_thai_d         = is_thai;
    assign slot_req[PORT_SW]   = sw_req;
    assign slot_req[PORT_KEY]  = key_req;
    assign slot_req[PORT_LANG] = (is_thai != prev_thai_q);
    assign slot_din[PORT_SW]   = sw_data;
    assign slot_din[PORT_KEY]  = key_data;
    assign slot_din[PORT_LANG] = {LANG_BYTE_PREFIX, is_thai};

    tx_req_slot u_slot_sw (
        .clk     (clk),
        .reset   (reset),
        .req     (slot_req[PORT_SW]),
        .data    (slot_din[PORT_SW]),
        .clear   (slot_clear[PORT_SW]),
        .pending (slot_pending[PORT_SW]),
        .q       (slot_q[PORT_SW]),
        .overflow(slot_ovf[PORT_SW])
    );

    tx_req_slot u_slot_key (
        .clk     (clk),
        .reset   (reset),
        .req     (slot_req[PORT_KEY]),
        .data    (slot_din[PORT_KEY]),
        .clear   (slot_clear[PORT_KEY]),
        .pending (slot_pending[PORT_KEY]),
        .q       (slot_q[PORT_KEY]),
        .overflow(slot_ovf[PORT_KEY])
    );

    tx_req_slot u_slot_lang (
        .clk     (clk),
        .reset   (reset),
        .req     (slot_req[PORT_LANG]),
        .data    (slot_din[PORT_LANG]),
        .clear   (slot_clear[PORT_LANG]),
        .pending (slot_pending[PORT_LANG]),
        .q       (slot_q[PORT_LANG]),
        .overflow(slot_ovf[PORT_LANG])
    );

    assign winner = pick_winner(slot_pending);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        send_data_d = send_data_q;
        grant_d     = grant_q;
        en_send_d   = 1'b0;
        dropped_d   = 1'b0;
        slot_clear  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|slot_pending) begin
                    slot_clear = winner;
                    grant_d    = winner;
                    en_send_d  = 1'b1;
                    state_d    = ST_SEND;
                    if (winner[PORT_LANG]) begin
                        send_data_d = slot_q[PORT_LANG];
                    end else if (winner[PORT_KEY]) begin
                        send_data_d = slot_q[PORT_KEY];
                    end else begin
                        send_data_d = slot_q[PORT_SW];
                    end
                end
            end
            ST_SEND: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q + CNT_W'(1) == BUSY_TC) begin
                    dropped_d = 1'b1;
                    cnt_d     = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_TC) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            send_data_q <= 8'h00;
            en_send_q   <= 1'b0;
            grant_q     <= '0;
            dropped_q   <= 1'b0;
            prev_thai_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            send_data_q <= send_data_d;
            en_send_q   <= en_send_d;
            grant_q     <= grant_d;
            dropped_q   <= dropped_d;
            prev_thai_q <= prev_thai_d;
        end
    end

    assign send_data = send_data_q;
    assign en_send   = en_send_q;
    assign grant     = grant_q;
    assign pending   = slot_pending;
    assign overflow  = |slot_ovf;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a scoreboard of expected bytes/grants
// checked on every en_send, plus cycle-exact checks of latency and timeout.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_req, key_req, is_thai, tx_busy;
    logic [7:0] sw_data, key_data;
    logic [7:0] send_data;
    logic       en_send, overflow, dropped;
    logic [2:0] grant, pending;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0, ovf_cnt = 0, drop_cnt = 0;
    int mark;
    bit busy_en  = 1'b1;
    int busy_len = 10;

    logic [7:0] exp_data[$];
    logic [2:0] exp_grant[$];

    uart_tx_scheduler #(.BUSY_TIMEOUT(8), .GAP_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_req   (sw_req),
        .sw_data  (sw_data),
        .key_req  (key_req),
        .key_data (key_data),
        .is_thai  (is_thai),
        .tx_busy  (tx_busy),
        .send_data(send_data),
        .en_send  (en_send),
        .grant    (grant),
        .pending  (pending),
        .overflow (overflow),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic nx(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] g);
        exp_data.push_back(d);
        exp_grant.push_back(g);
    endtask

    task automatic wait_drain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_data.size() != 0; i++) nx();
        chk(tag, exp_data.size(), 0);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound && grant != 3'b000; i++) nx();
        chk(tag, grant, 3'b000);
    endtask

    // Scoreboard and pulse counters, all sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (overflow === 1'b1) ovf_cnt++;
            if (dropped === 1'b1) drop_cnt++;
            if (en_send === 1'b1) begin
                en_cnt++;
                chk("en_send_expected", exp_data.size() > 0, 1);
                if (exp_data.size() > 0) begin
                    chk("sb_send_data", send_data, exp_data.pop_front());
                    chk("sb_grant", grant, exp_grant.pop_front());
                end
            end
        end
    end

    // UART model: busy from the cycle after en_send for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (en_send === 1'b1 && busy_en) begin
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1; sw_req = 1'b0; key_req = 1'b0; is_thai = 1'b0;
        sw_data = 8'h00; key_data = 8'h00;
        nx(3);
        chk("rst_send_data", send_data, 8'h00);
        chk("rst_en_send", en_send, 1'b0);
        chk("rst_grant", grant, 3'b000);
        chk("rst_pending", pending, 3'b000);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_dropped", dropped, 1'b0);
        reset = 1'b0;
        nx(3);

        // Single keyboard byte with 10-cycle busy.
        key_data = 8'h41; key_req = 1'b1; push(8'h41, 3'b010);
        nx(); key_req = 1'b0;
        chk("k1_pending_n1", pending, 3'b010);
        chk("k1_no_send_n1", en_send, 1'b0);
        nx();
        chk("k1_en_send_n2", en_send, 1'b1);
        chk("k1_data_n2", send_data, 8'h41);
        chk("k1_grant_n2", grant, 3'b010);
        chk("k1_pending_n2", pending, 3'b000);
        nx();
        chk("k1_strobe_one_cycle", en_send, 1'b0);
        nx(26);
        chk("k1_grant_held_gap_end", grant, 3'b010);
        nx();
        chk("k1_grant_idle", grant, 3'b000);
        chk("k1_data_held", send_data, 8'h41);

        // Three simultaneous requests drain lang, key, sw.
        mark = ovf_cnt;
        sw_data = 8'h12; sw_req = 1'b1; key_data = 8'h61; key_req = 1'b1; is_thai = 1'b1;
        push(8'h01, 3'b100); push(8'h61, 3'b010); push(8'h12, 3'b001);
        nx(); sw_req = 1'b0; key_req = 1'b0;
        chk("sim_pending_all", pending, 3'b111);
        wait_drain("sim_drain", 200);
        wait_idle("sim_idle", 100);
        chk("sim_no_overflow", ovf_cnt - mark, 0);

        // Overwrite of the sw slot while a key byte is in flight.
        mark = ovf_cnt;
        key_data = 8'h55; key_req = 1'b1; push(8'h55, 3'b010);
        nx(); key_req = 1'b0;
        nx(4);
        sw_data = 8'h10; sw_req = 1'b1;
        nx(); sw_data = 8'h20;
        nx(); sw_req = 1'b0; push(8'h20, 3'b001);
        chk("ovw_pending_sw", pending, 3'b001);
        nx();
        chk("ovw_one_overflow", ovf_cnt - mark, 1);
        wait_drain("ovw_drain", 200);
        wait_idle("ovw_idle", 100);

        // Timeout with tx_busy stuck low; next slot granted after the gap.
        busy_en = 1'b0;
        mark = drop_cnt;
        key_data = 8'h33; key_req = 1'b1; sw_data = 8'h44; sw_req = 1'b1;
        push(8'h33, 3'b010); push(8'h44, 3'b001);
        nx(); key_req = 1'b0; sw_req = 1'b0;
        nx();
        chk("to_en_send", en_send, 1'b1);
        nx(8);
        chk("to_not_yet_dropped", dropped, 1'b0);
        nx();
        chk("to_dropped_pulse", dropped, 1'b1);
        nx();
        chk("to_dropped_one_cycle", dropped, 1'b0);
        nx(15);
        chk("to_idle_after_gap", grant, 3'b000);
        nx();
        chk("to_next_en_send", en_send, 1'b1);
        chk("to_next_grant", grant, 3'b001);
        wait_drain("to_drain", 100);
        wait_idle("to_idle", 100);
        mark = en_cnt;
        nx(30);
        chk("to_no_retry", en_cnt - mark, 0);
        chk("to_pending_empty", pending, 3'b000);
        busy_en = 1'b1;

        // Reset during WAIT_DONE with lang and sw pending.
        busy_len = 20;
        key_data = 8'h70; key_req = 1'b1; push(8'h70, 3'b010);
        nx(); key_req = 1'b0;
        nx(3);
        is_thai = 1'b0; sw_data = 8'h71; sw_req = 1'b1;
        nx(); sw_req = 1'b0;
        chk("rmt_pending", pending, 3'b101);
        nx();
        reset = 1'b1;
        exp_data.delete(); exp_grant.delete();
        #1;
        chk("rmt_grant", grant, 3'b000);
        chk("rmt_pending_clr", pending, 3'b000);
        chk("rmt_send_data", send_data, 8'h00);
        chk("rmt_en_send", en_send, 1'b0);
        nx(2);
        mark = en_cnt;
        reset = 1'b0;
        nx(40);
        chk("rmt_no_send_after", en_cnt - mark, 0);

        // is_thai already high at reset release yields exactly one 0x01.
        busy_len = 3;
        reset = 1'b1; is_thai = 1'b1;
        nx(2);
        mark = en_cnt;
        push(8'h01, 3'b100);
        reset = 1'b0;
        wait_drain("thai_drain", 50);
        wait_idle("thai_idle", 100);
        nx(30);
        chk("thai_one_byte", en_cnt - mark, 1);
        chk("thai_pending_empty", pending, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
